// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx transmitter between NREQ packet producers. A requester
//   is chosen round-robin in IDLE, its packet is latched into tx_data, and a
//   one-cycle send_data pulse starts uart_tx. The block counts the serial frame
//   itself (BIT_CLKS*FRAME_BITS clocks), pulses done for the owner, and then
//   waits GAP_CLKS idle-line clocks before arbitrating again.
//
//   Optional feature: define UART_TX_ARB_PRIO0_EN to give requester 0 absolute
//   priority in IDLE. The others then arbitrate round-robin among themselves,
//   and grants to requester 0 leave the round-robin pointer untouched.
//
//   Ports
//     clk        in   system clock, rising edge
//     n_rst      in   asynchronous reset, active-HIGH (1 = reset)
//     req        in   [NREQ]        level request per requester, held until ack
//     req_data   in   [NREQ*DATA_W] packet i at [i*DATA_W +: DATA_W]
//     ack        out  [NREQ]        one-hot pulse: packet i latched
//     done       out  [NREQ]        one-hot pulse: packet i fully shifted out
//     tx_data    out  [DATA_W]      registered packet to uart_tx
//     send_data  out                one-cycle start pulse to uart_tx
//     busy       out                high in every state except IDLE
module uart_tx_arbiter #(
   parameter int NREQ       = 4,
   parameter int DATA_W     = 288,
   parameter int BIT_CLKS   = 10,
   parameter int FRAME_BITS = 360,
   parameter int GAP_CLKS   = 2
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        done,
   output logic [DATA_W-1:0]      tx_data,
   output logic                   send_data,
   output logic                   busy
);

   localparam int FRAME_CLKS = BIT_CLKS * FRAME_BITS;
   localparam int CNT_W      = $clog2(FRAME_CLKS);
   localparam int PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CLKS - 1);
   localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);
   localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NREQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  r_owner;
   logic [DATA_W-1:0] r_tx_data;
   logic [NREQ-1:0]   r_ack;
   logic [NREQ-1:0]   r_done;
   logic              r_send;
   logic              r_busy;

   logic              w_found;
   logic              w_upd_ptr;
   logic [PTR_W-1:0]  w_win;
   logic [NREQ-1:0]   w_win_hot;
   logic [NREQ-1:0]   w_own_hot;

   // Winner search: walk the ring starting one past the last granted index.
   // With the priority option, requester 0 is claimed up front; when req[0]
   // is low the ring walk can never land on 0, so no extra exclusion is needed.
   always_comb begin
      int idx_sum;
      w_found   = 1'b0;
      w_upd_ptr = 1'b0;
      w_win     = '0;
      idx_sum   = 0;
`ifdef UART_TX_ARB_PRIO0_EN
      if (req[0]) begin
         w_found = 1'b1;
         w_win   = '0;
      end
`endif
      for (int i = 1; i <= NREQ; i++) begin
         idx_sum = int'(r_ptr) + i;
         if (idx_sum >= NREQ) idx_sum = idx_sum - NREQ;
         if (!w_found && req[PTR_W'(idx_sum)]) begin
            w_found   = 1'b1;
            w_upd_ptr = 1'b1;
            w_win     = PTR_W'(idx_sum);
         end
      end
   end

   assign w_win_hot = NREQ'(1) << w_win;
   assign w_own_hot = NREQ'(1) << r_owner;

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_ptr     <= PTR_RST;
         r_owner   <= '0;
         r_tx_data <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_send    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_ack  <= '0;
         r_done <= '0;
         r_send <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state   <= S_LOAD;
                  r_tx_data <= req_data[int'(w_win)*DATA_W +: DATA_W];
                  r_owner   <= w_win;
                  if (w_upd_ptr) r_ptr <= w_win;
                  r_ack     <= w_win_hot;
                  r_send    <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            S_LOAD: begin
               r_state <= S_SEND;
               r_cnt   <= '0;
               // Degenerate one-clock frame: terminal count is the first SEND cycle.
               if (LAST_CNT == '0) r_done <= w_own_hot;
            end
            S_SEND: begin
               if (r_cnt == LAST_CNT) begin
                  r_cnt <= '0;
                  if (GAP_CLKS == 0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_GAP;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  // done is registered, so it is raised one count early to
                  // coincide with the terminal-count cycle.
                  if (r_cnt == LAST_CNT - 1'b1) r_done <= w_own_hot;
               end
            end
            S_GAP: begin
               if (r_cnt == LAST_GAP) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ack       = r_ack;
   assign done      = r_done;
   assign tx_data   = r_tx_data;
   assign send_data = r_send;
   assign busy      = r_busy;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter (36-byte, 360-bit framed packets) between `NREQ` requesters. The block arbitrates round-robin, latches the winner's packet, drives `tx_data`/`send_data` into `uart_tx`, and times the frame itself so the next packet is issued only after the previous one has fully shifted out. It sits between the packet producers and `uart_tx`, in the same clock domain.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DATA_W`, 288, packet width in bits (36 bytes)
- `BIT_CLKS`, 10, clocks per serial bit on `uart_tx`
- `FRAME_BITS`, 360, serial bits per packet (start + 8 data + stop per byte)
- `GAP_CLKS`, 2, idle-line clocks inserted after each frame (0 allowed)

- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous reset, active-high (1 = reset) despite the name
- `req`  in  NREQ  level request per requester; held until `ack`
- `req_data`  in  NREQ*DATA_W  packet for requester i at `[i*DATA_W +: DATA_W]`
- `ack`  out  NREQ  one-hot, 1-cycle pulse: packet i latched
- `done`  out  NREQ  one-hot, 1-cycle pulse: packet i fully shifted out
- `tx_data`  out  DATA_W  registered packet to `uart_tx`
- `send_data`  out  1  1-cycle start pulse to `uart_tx`
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE: if any `req` bit set at a rising edge -> pick winner w, latch `req_data[w]` into `tx_data`, record owner = w, go LOAD. No request -> stay.
- LOAD (exactly 1 cycle): `ack[w]` = 1 and `send_data` = 1; frame counter cleared; -> SEND.
- SEND: counter increments each cycle from 0; on count = `BIT_CLKS*FRAME_BITS`-1 -> `done[owner]` = 1 in that cycle, counter cleared, -> GAP (or IDLE if `GAP_CLKS` = 0).
- GAP: `GAP_CLKS` cycles, then -> IDLE.
- Round-robin: pointer = last granted index; search starts at pointer+1 mod NREQ. Pointer updates on entry to LOAD.
- `tx_data` stable from LOAD through end of GAP; changes only on an IDLE->LOAD transition.
- `req` bits changing during LOAD/SEND/GAP are ignored until IDLE. Requester dropping `req` before being granted: no effect, not queued.
- Requester still asserting `req` in the cycle after its `ack` is treated as a new request.
- Counter width `$clog2(BIT_CLKS*FRAME_BITS)`; no wrap other than the defined terminal count.
- Outputs `ack`, `done`, `send_data`, `busy` decoded from registered state/counter/owner only; no combinational path from `req` to any output.

## Timing
- Reset (`n_rst` = 1, any time, asynchronous): state IDLE, counter 0, `tx_data` = 0, `ack` = 0, `done` = 0, `send_data` = 0, `busy` = 0, pointer = NREQ-1 (requester 0 wins first). Frame in progress is abandoned, no `done`.
- `req` sampled at edge E0 in IDLE -> LOAD cycle t (`ack`, `send_data`, `busy` high); SEND t+1..t+3600 (defaults); `done` in cycle t+3600; GAP t+3601..t+3602; IDLE t+3603; earliest next LOAD t+3604.
- Minimum spacing between consecutive `send_data` pulses: `BIT_CLKS*FRAME_BITS` + `GAP_CLKS` + 2 cycles.
- `ack` and `send_data` are always coincident; `done` always one per `ack`, same index.

## Configuration
- `UART_TX_ARB_PRIO0_EN` defined: requester 0 has absolute priority; when `req[0]` is set in IDLE it wins regardless of pointer; other requesters arbitrate round-robin among themselves; pointer unaffected by grants to 0.
- Not defined: pure round-robin across all NREQ requesters.

## Test plan
- Reset, then `req` = 4'b0001 with `req_data[0]` = 288'hA5..A5 -> `ack` = 4'b0001 and `send_data` in cycle t, `tx_data` = A5..A5, `done` = 4'b0001 at t+3600, `busy` low at t+3603.
- `req` = 4'b1011 held, each dropped on own `ack` -> grant order 0, 1, 3; `send_data` spacing 3604 cycles; three `done` pulses matching.
- `req[2]` held continuously after `ack` -> with others idle, re-granted every 3604 cycles; with `req[0]` also set, alternates 0, 2, 0, 2.
- `UART_TX_ARB_PRIO0_EN` defined, `req` = 4'b1111 with 1,2,3 held and `req[0]` re-raised each IDLE -> 0 wins every frame; without macro -> 0,1,2,3.
- `n_rst` pulsed at SEND count 1000 -> all outputs 0 immediately, no `done`; pending `req` = 4'b0100 after release -> `ack` = 4'b0100 on first IDLE edge.
- `GAP_CLKS` = 0, `req[1]` held -> `done` at t+3600, IDLE t+3601, next `ack` t+3602; `req` pulsed for one cycle during SEND -> ignored.
